// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit: the access-size
// encoding carried on req_size, the unit's FSM states, the data-word geometry
// and a helper that flags requests the unit must reject.
// ---------------------------------------------------------------------------
package lsu_pkg;

  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  // Encoding 2'd3 is reserved and is always rejected as an error.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

  // A request is rejected when its size is reserved or when it is not
  // naturally aligned within the word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational byte-lane steering for the load/store unit.
//   size_i    access size (byte / half / word)
//   signed_i  sign-extend sub-word load results
//   offset_i  byte offset of the access inside the word
//   rdata_i   word read from memory
//   wdata_i   right-aligned store data
//   load_o    addressed lane of rdata_i, zero/sign-extended to a full word
//   merge_o   rdata_i with the addressed lane(s) replaced by wdata_i
// Only aligned accesses reach this block, so a half access always sits at
// offset 0 or 2 and a word access at offset 0.
// ---------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]                        size_i,
  input  logic                              signed_i,
  input  logic [$clog2(BYTES_PER_WORD)-1:0] offset_i,
  input  logic [DATA_W-1:0]                 rdata_i,
  input  logic [DATA_W-1:0]                 wdata_i,
  output logic [DATA_W-1:0]                 load_o,
  output logic [DATA_W-1:0]                 merge_o
);

  logic [4:0]        shiftAmt;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] laneMask;

  // The addressed lane is moved down to bit 0 for loads; for stores the
  // right-aligned data is moved up under a mask covering the same lane.
  always_comb begin
    shiftAmt = {offset_i, 3'b000};
    shifted  = rdata_i >> shiftAmt;
    load_o   = rdata_i;
    laneMask = 32'hFFFF_FFFF;
    case (size_i)
      SZ_BYTE: begin
        load_o   = {{24{signed_i & shifted[7]}}, shifted[7:0]};
        laneMask = 32'h0000_00FF << shiftAmt;
      end
      SZ_HALF: begin
        load_o   = {{16{signed_i & shifted[15]}}, shifted[15:0]};
        laneMask = 32'h0000_FFFF << shiftAmt;
      end
      default: begin
        load_o   = rdata_i;
        laneMask = 32'hFFFF_FFFF;
      end
    endcase
    merge_o = (rdata_i & ~laneMask) | ((wdata_i << shiftAmt) & laneMask);
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Core-side initiator for a word-organised data memory. Takes one load or
// store at a time, drives registered memory pins, and returns load data or a
// store acknowledge. Sub-word stores are done as read-modify-write because
// the memory only writes whole words.
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_*_i / req_ready_o  request port (valid/ready, accepted only in IDLE)
//   rsp_*_o / rsp_ready_i  response port (held until accepted)
//   mem_addr_o             word address to memory
//   mem_wdata_o, mem_we_o  write word and single-cycle write strobe
//   mem_rdata_i            combinational read word from memory
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W+1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;

  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] mergeData;

  lsu_align u_align (
    .size_i   (size_q),
    .signed_i (signed_q),
    .offset_i (offset_q),
    .rdata_i  (mem_rdata_i),
    .wdata_i  (wdata_q),
    .load_o   (loadData),
    .merge_o  (mergeData)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;

  // Request capture, FSM and registered memory pins. mem_addr and a word
  // store's write data are loaded on the handshake edge so they are already
  // valid throughout ACCESS; mem_we is a one-cycle pulse that defaults low
  // every cycle, so an async reset in WRITE cancels the pending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      offset_q    <= 2'd0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            write_q     <= req_write_i;
            size_q      <= req_size_i;
            signed_q    <= req_signed_i;
            offset_q    <= req_addr_i[1:0];
            wdata_q     <= req_wdata_i;
            rsp_rdata_q <= '0;
            if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
              rsp_err_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              rsp_err_q  <= 1'b0;
              mem_addr_q <= req_addr_i[ADDR_W+1:2];
              if (req_write_i && (req_size_i == SZ_WORD)) begin
                mem_wdata_q <= req_wdata_i;
                mem_we_q    <= 1'b1;
              end
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!write_q) begin
            rsp_rdata_q <= loadData;
            state_q     <= ST_RESP;
          end else if (size_q == SZ_WORD) begin
            state_q <= ST_RESP;
          end else begin
            // Old word is on mem_rdata now; write back the merged word next.
            mem_wdata_q <= mergeData;
            mem_we_q    <= 1'b1;
            state_q     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Drives the load/store unit against a word memory model, predicts every
// response from a byte-level reference memory, and checks each meaningful
// cycle from a single negedge monitor.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rstN;
   logic              reqValid;
   logic              reqReady;
   logic              reqWrite;
   logic [1:0]        reqSize;
   logic              reqSigned;
   logic [ADDR_W+1:0] reqAddr;
   logic [31:0]       reqWdata;
   logic              rspValid;
   logic              rspReady;
   logic [31:0]       rspRdata;
   logic              rspErr;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memWdata;
   logic              memWe;
   logic [31:0]       memRdata;

   logic [31:0] memArr [0:255];
   logic [31:0] refMem [0:255];
   bit          memReady = 1'b0;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int hsCycle = 0;
   bit busy = 1'b0;
   bit monEn = 1'b1;
   int weCount = 0;
   int age;
   bit weExp;

   logic [31:0] expRdata;
   logic [31:0] expNew;
   bit          expErr;
   bit          expWe;
   int          expLat;
   int          expIdx;

   logic [31:0] lastRdata;
   bit          lastErr;
   int          lastLat;
   int          hsWait;
   int          weBefore;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_write_i  (reqWrite),
      .req_size_i   (reqSize),
      .req_signed_i (reqSigned),
      .req_addr_i   (reqAddr),
      .req_wdata_i  (reqWdata),
      .rsp_valid_o  (rspValid),
      .rsp_ready_i  (rspReady),
      .rsp_rdata_o  (rspRdata),
      .rsp_err_o    (rspErr),
      .mem_addr_o   (memAddr),
      .mem_wdata_o  (memWdata),
      .mem_we_o     (memWe),
      .mem_rdata_i  (memRdata)
   );

   // Free-running clock and a cycle count used to time responses.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [31:0] seedWord(input int i);
      return (32'(i) * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
   endfunction

   // Data memory seen by the unit: filled with a known pattern on the first
   // edge, then written whole-word whenever the write strobe is high.
   always @(posedge clk) begin
      if (!memReady) begin
         for (int i = 0; i < 256; i++) memArr[i] <= seedWord(i);
         memReady <= 1'b1;
      end else if (memWe) begin
         memArr[memAddr] <= memWdata;
      end
   end

   assign memRdata = memArr[memAddr];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference prediction from the access rules, byte by byte.
   task automatic computeModel(input bit wr, input logic [1:0] sz, input bit sg,
                               input logic [9:0] ad, input logic [31:0] wd);
      int off;
      int nBytes;
      logic [31:0] old;
      logic [31:0] v;
      off = int'(ad[1:0]);
      expIdx = int'(ad[9:2]);
      old = refMem[expIdx];
      expErr = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0);
      nBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      expLat = expErr ? 1 : ((!wr || sz == 2'd2) ? 2 : 3);
      expWe = wr && !expErr;
      expNew = old;
      expRdata = 32'd0;
      if (!expErr) begin
         if (wr) begin
            for (int b = 0; b < nBytes; b++) expNew[8*(off+b) +: 8] = wd[8*b +: 8];
         end else begin
            v = 32'd0;
            for (int b = 0; b < nBytes; b++) v[8*b +: 8] = old[8*(off+b) +: 8];
            if (sg && v[8*nBytes-1]) begin
               for (int b = nBytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
            end
            expRdata = v;
         end
      end
   endtask

   // One complete transaction: handshake, wait for the response while
   // throwing ignored requests at the busy unit, optional back-pressure,
   // then accept and commit the store to the reference memory.
   task automatic applyStimulus(input bit wr, input logic [1:0] sz, input bit sg,
                                input logic [9:0] ad, input logic [31:0] wd,
                                input int hold, input bit pre);
      int waited;
      int n;
      computeModel(wr, sz, sg, ad, wd);
      rspReady = pre;
      reqValid = 1'b1;
      reqWrite = wr;
      reqSize = sz;
      reqSigned = sg;
      reqAddr = ad;
      reqWdata = wd;
      waited = 0;
      while (!reqReady && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      hsWait = waited;
      if (!reqReady) begin
         checkOutput("handshake timeout", 32'(reqReady), 32'd1);
         reqValid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      hsCycle = cycle;
      busy = 1'b1;
      n = 0;
      while (!rspValid && n < 10) begin
         reqValid = 1'($urandom);
         reqWrite = 1'($urandom);
         reqSize = 2'($urandom);
         reqAddr = 10'($urandom);
         reqWdata = $urandom;
         @(posedge clk); #1;
         n++;
      end
      reqValid = 1'b0;
      lastLat = n + 1;
      checkOutput("latency", 32'(lastLat), 32'(expLat));
      lastRdata = rspRdata;
      lastErr = rspErr;
      if (!pre) begin
         repeat (hold) begin
            @(posedge clk); #1;
         end
         rspReady = 1'b1;
      end
      @(posedge clk); #1;
      busy = 1'b0;
      rspReady = 1'b0;
      if (expWe) refMem[expIdx] = expNew;
   endtask

   // Cycle-by-cycle compare of the unit's outputs against the prediction
   // for the transaction in flight, or against the idle expectations.
   always @(negedge clk) begin
      if (monEn && rstN) begin
         if (busy) begin
            age = cycle - hsCycle + 1;
            checkOutput("rsp_valid timing", 32'(rspValid), 32'(age >= expLat));
            if (rspValid) begin
               checkOutput("rsp_rdata", rspRdata, expRdata);
               checkOutput("rsp_err", 32'(rspErr), 32'(expErr));
            end
            checkOutput("req_ready while busy", 32'(reqReady), 32'd0);
            weExp = expWe && (age == expLat - 1);
            checkOutput("mem_we timing", 32'(memWe), 32'(weExp));
            if (memWe && weExp) begin
               checkOutput("mem_addr", 32'(memAddr), 32'(expIdx));
               checkOutput("mem_wdata", memWdata, expNew);
            end
         end else begin
            checkOutput("req_ready idle", 32'(reqReady), 32'd1);
            checkOutput("rsp_valid idle", 32'(rspValid), 32'd0);
            checkOutput("mem_we idle", 32'(memWe), 32'd0);
         end
         if (memWe) weCount++;
      end
   end

   // Bound on total run time.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reset, directed scenarios with literal expectations, random traffic,
   // final memory comparison and summary.
   initial begin
      rstN = 1'b1;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqSize = 2'd0;
      reqSigned = 1'b0;
      reqAddr = '0;
      reqWdata = '0;
      rspReady = 1'b0;
      for (int i = 0; i < 256; i++) refMem[i] = seedWord(i);
      #2 rstN = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      #1;
      checkOutput("reset req_ready", 32'(reqReady), 32'd1);
      checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("reset rsp_rdata", rspRdata, 32'd0);
      checkOutput("reset rsp_err", 32'(rspErr), 32'd0);
      checkOutput("reset mem_we", 32'(memWe), 32'd0);
      checkOutput("reset mem_addr", 32'(memAddr), 32'd0);
      checkOutput("reset mem_wdata", memWdata, 32'd0);

      // Word store then word load.
      weBefore = weCount;
      applyStimulus(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0, 1'b0);
      checkOutput("t1 store we pulses", 32'(weCount - weBefore), 32'd1);
      checkOutput("t1 memory word", memArr[4], 32'hDEADBEEF);
      weBefore = weCount;
      applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 0, 1'b0);
      checkOutput("t1 load data", lastRdata, 32'hDEADBEEF);
      checkOutput("t1 load err", 32'(lastErr), 32'd0);
      checkOutput("t1 load we pulses", 32'(weCount - weBefore), 32'd0);

      // Byte store read-modify-write.
      applyStimulus(1'b1, 2'd2, 1'b0, 10'h004, 32'h11223344, 0, 1'b0);
      weBefore = weCount;
      applyStimulus(1'b1, 2'd0, 1'b0, 10'h005, 32'h000000AB, 0, 1'b0);
      checkOutput("t2 byte store latency", 32'(lastLat), 32'd3);
      checkOutput("t2 byte store we pulses", 32'(weCount - weBefore), 32'd1);
      checkOutput("t2 merged word", memArr[1], 32'h1122AB44);

      // Signed and unsigned sub-word loads.
      applyStimulus(1'b1, 2'd0, 1'b0, 10'h008, 32'h00000080, 0, 1'b1);
      applyStimulus(1'b0, 2'd0, 1'b1, 10'h008, 32'd0, 0, 1'b0);
      checkOutput("t3 signed byte", lastRdata, 32'hFFFFFF80);
      applyStimulus(1'b0, 2'd0, 1'b0, 10'h008, 32'd0, 0, 1'b0);
      checkOutput("t3 unsigned byte", lastRdata, 32'h00000080);
      applyStimulus(1'b1, 2'd1, 1'b0, 10'h00A, 32'h00008001, 0, 1'b0);
      applyStimulus(1'b0, 2'd1, 1'b1, 10'h00A, 32'd0, 0, 1'b0);
      checkOutput("t3 signed half", lastRdata, 32'hFFFF8001);

      // Misaligned requests.
      weBefore = weCount;
      applyStimulus(1'b0, 2'd1, 1'b0, 10'h003, 32'd0, 0, 1'b0);
      checkOutput("t4 half err", 32'(lastErr), 32'd1);
      checkOutput("t4 half rdata", lastRdata, 32'd0);
      checkOutput("t4 half latency", 32'(lastLat), 32'd1);
      applyStimulus(1'b1, 2'd2, 1'b0, 10'h002, 32'h55555555, 0, 1'b0);
      checkOutput("t4 word err", 32'(lastErr), 32'd1);
      checkOutput("t4 word latency", 32'(lastLat), 32'd1);
      checkOutput("t4 no we pulses", 32'(weCount - weBefore), 32'd0);
      checkOutput("t4 memory unchanged", memArr[0], refMem[0]);

      // Held response then back-to-back acceptance.
      applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, 5, 1'b0);
      checkOutput("t5 held data", lastRdata, 32'hDEADBEEF);
      applyStimulus(1'b0, 2'd2, 1'b0, 10'h004, 32'd0, 0, 1'b0);
      checkOutput("t5 back-to-back wait", 32'(hsWait), 32'd0);
      checkOutput("t5 next load data", lastRdata, 32'h1122AB44);

      // Reset pulsed during the write phase of a byte store.
      monEn = 1'b0;
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqSize = 2'd0;
      reqSigned = 1'b0;
      reqAddr = 10'h014;
      reqWdata = 32'h000000CD;
      @(posedge clk); #1;
      reqValid = 1'b0;
      checkOutput("t6 ready in access", 32'(reqReady), 32'd0);
      @(posedge clk); #1;
      checkOutput("t6 we in write", 32'(memWe), 32'd1);
      checkOutput("t6 write data", memWdata, {refMem[5][31:8], 8'hCD});
      rstN = 1'b0;
      #1;
      checkOutput("t6 we async clear", 32'(memWe), 32'd0);
      checkOutput("t6 ready in reset", 32'(reqReady), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk); #1;
      checkOutput("t6 word unchanged", memArr[5], refMem[5]);
      checkOutput("t6 rsp_valid after reset", 32'(rspValid), 32'd0);
      checkOutput("t6 ready after reset", 32'(reqReady), 32'd1);
      monEn = 1'b1;

      // Random traffic over a small window so loads hit earlier stores.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                       10'($urandom_range(0, 63)), $urandom,
                       int'($urandom_range(0, 2)), 1'($urandom));
      end

      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("final word %0d", i), memArr[i], refMem[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
